// File: rtl/eth_tx_framer.sv
// GMII transmit framer: preamble/SFD insertion, CRC-32 FCS append and inter-packet gap.
// Define ETH_TX_MIN_PAD_EN to zero-pad short payloads up to MIN_FRAME bytes before the FCS.
module eth_tx_framer #(
  parameter int PREAMBLE_LEN = 7,
  parameter int IFG_BYTES    = 12,
`ifdef ETH_TX_MIN_PAD_EN
  parameter int MIN_FRAME    = 60,
`endif
  parameter int MAX_FRAME    = 1514
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  input  logic       i_last,
  output logic       o_ready,
  output logic [7:0] o_data,
  output logic       o_tx_en,
  output logic       o_busy,
  output logic       o_frame_done,
  output logic       o_error
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_DATA,
`ifdef ETH_TX_MIN_PAD_EN
    ST_PAD,
`endif
    ST_FCS,
    ST_IFG
  } state_t;

  localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_LEN);
  localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 1);
  localparam logic [10:0] MAX_CNT  = 11'(MAX_FRAME);
`ifdef ETH_TX_MIN_PAD_EN
  localparam logic [10:0] MIN_CNT  = 11'(MIN_FRAME);
`endif

  // Reflected CRC-32 (poly 0xEDB88320) advanced by one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h00_0000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  state_t      state_r;
  logic [7:0]  step_r;
  logic [10:0] byte_cnt_r;
  logic [31:0] crc_r;
  logic        corrupt_r;
  logic [1:0]  fcs_idx_r;

  logic        xfer_s;
  logic [10:0] byte_cnt_inc_s;
  logic [31:0] fcs_word_s;
  logic [7:0]  fcs_byte_s;

  assign o_ready        = (state_r == ST_SFD) || (state_r == ST_DATA);
  assign xfer_s         = i_valid & o_ready;
  assign byte_cnt_inc_s = (byte_cnt_r == 11'h7FF) ? byte_cnt_r : (byte_cnt_r + 11'd1);

  // FCS byte select; an aborted frame sends the un-inverted register, i.e. the complement of the good FCS.
  always_comb begin
    fcs_word_s = corrupt_r ? crc_r : ~crc_r;
    case (fcs_idx_r)
      2'd0:    fcs_byte_s = fcs_word_s[7:0];
      2'd1:    fcs_byte_s = fcs_word_s[15:8];
      2'd2:    fcs_byte_s = fcs_word_s[23:16];
      2'd3:    fcs_byte_s = fcs_word_s[31:24];
      default: fcs_byte_s = fcs_word_s[7:0];
    endcase
  end

  // Framing FSM; the state names what the next clock edge will put on the wire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      step_r       <= 8'd0;
      byte_cnt_r   <= 11'd0;
      crc_r        <= 32'hFFFF_FFFF;
      corrupt_r    <= 1'b0;
      fcs_idx_r    <= 2'd0;
      o_data       <= 8'h00;
      o_tx_en      <= 1'b0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
      o_error      <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      o_error      <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          byte_cnt_r <= 11'd0;
          crc_r      <= 32'hFFFF_FFFF;
          corrupt_r  <= 1'b0;
          fcs_idx_r  <= 2'd0;
          if (i_valid) begin
            state_r <= ST_PREAMBLE;
            step_r  <= 8'd1;
            o_data  <= 8'h55;
            o_tx_en <= 1'b1;
            o_busy  <= 1'b1;
          end else begin
            step_r  <= 8'd0;
            o_data  <= 8'h00;
            o_tx_en <= 1'b0;
            o_busy  <= 1'b0;
          end
        end
        ST_PREAMBLE: begin
          if (step_r == PRE_LAST) begin
            state_r <= ST_SFD;
            step_r  <= 8'd0;
            o_data  <= 8'hD5;
          end else begin
            step_r  <= step_r + 8'd1;
            o_data  <= 8'h55;
          end
        end
        ST_SFD, ST_DATA: begin
          if (xfer_s) begin
            o_data     <= i_data;
            crc_r      <= crc32_byte(crc_r, i_data);
            byte_cnt_r <= byte_cnt_inc_s;
            if (i_last) begin
`ifdef ETH_TX_MIN_PAD_EN
              state_r <= (byte_cnt_inc_s < MIN_CNT) ? ST_PAD : ST_FCS;
`else
              state_r <= ST_FCS;
`endif
            end else if (byte_cnt_inc_s >= MAX_CNT) begin
              state_r   <= ST_FCS;
              corrupt_r <= 1'b1;
              o_error   <= 1'b1;
            end else begin
              state_r <= ST_DATA;
            end
          end else begin
            // Underrun: first corrupted FCS byte goes out immediately so TX_EN never carries a bubble.
            state_r   <= ST_FCS;
            o_data    <= crc_r[7:0];
            fcs_idx_r <= 2'd1;
            corrupt_r <= 1'b1;
            o_error   <= 1'b1;
          end
        end
`ifdef ETH_TX_MIN_PAD_EN
        ST_PAD: begin
          o_data     <= 8'h00;
          crc_r      <= crc32_byte(crc_r, 8'h00);
          byte_cnt_r <= byte_cnt_inc_s;
          if (byte_cnt_inc_s >= MIN_CNT) begin
            state_r <= ST_FCS;
          end else begin
            state_r <= ST_PAD;
          end
        end
`endif
        ST_FCS: begin
          o_data    <= fcs_byte_s;
          fcs_idx_r <= fcs_idx_r + 2'd1;
          if (fcs_idx_r == 2'd3) begin
            state_r <= ST_IFG;
            step_r  <= 8'd0;
          end else begin
            state_r <= ST_FCS;
          end
        end
        ST_IFG: begin
          o_data  <= 8'h00;
          o_tx_en <= 1'b0;
          o_busy  <= 1'b1;
          if (step_r == 8'd0) begin
            o_frame_done <= 1'b1;
          end else begin
            o_frame_done <= 1'b0;
          end
          if (step_r == IFG_LAST) begin
            state_r <= ST_IDLE;
            step_r  <= 8'd0;
          end else begin
            step_r  <= step_r + 8'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          o_data  <= 8'h00;
          o_tx_en <= 1'b0;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Scoreboard bench for eth_tx_framer: driver queues expected wire bytes, negedge monitor checks them.
module tb_eth_tx_framer;

  localparam int MAXF = 1514;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] i_data;
  logic       i_valid;
  logic       i_last;
  logic       o_ready;
  logic [7:0] o_data;
  logic       o_tx_en;
  logic       o_busy;
  logic       o_frame_done;
  logic       o_error;

  always #4 clk = ~clk;

  eth_tx_framer dut (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_valid(i_valid), .i_last(i_last),
    .o_ready(o_ready), .o_data(o_data), .o_tx_en(o_tx_en), .o_busy(o_busy),
    .o_frame_done(o_frame_done), .o_error(o_error)
  );

  typedef struct {
    int len;
    int err;
  } frame_t;

  logic [7:0]  exp_q[$];
  frame_t      frame_q[$];
  logic [7:0]  pay[$];
  int          n_vec = 0;
  int          n_bad = 0;
  bit          exact_gap = 1'b0;
  bit          use_fcs_ovr = 1'b0;
  logic [31:0] fcs_ovr = 32'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm, input int act, input int exp);
    n_vec++;
    n_bad++;
    $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference FCS straight from the definition: reflected CRC-32 over the bit stream, LSB of each byte first.
  function automatic logic [31:0] crc_model(input logic [7:0] b[$]);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFF_FFFF;
    foreach (b[k]) begin
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ b[k][j];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB8_8320;
      end
    end
    return ~c;
  endfunction

  // Monitor state
  bit     prev_tx = 1'b0;
  bit     have_gap = 1'b0;
  bit     fall;
  int     run_len = 0;
  int     err_seen = 0;
  int     gap = 0;
  frame_t fr_m;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_tx  = 1'b0;
      have_gap = 1'b0;
      run_len  = 0;
      err_seen = 0;
      gap      = 0;
    end else begin
      fall = prev_tx && !o_tx_en;
      chk("frame_done", 32'(o_frame_done), 32'(fall));
      if (o_error) err_seen++;
      if (o_tx_en) begin
        if (!prev_tx && have_gap) begin
          if (exact_gap) chk("ifg_exact", 32'(gap), 32'd12);
          else if (gap < 12) fail("ifg_short", gap, 12);
          else chk("ifg_min", 32'(gap >= 12), 32'd1);
        end
        chk("busy_in_frame", 32'(o_busy), 32'd1);
        if (exp_q.size() == 0) fail("unexpected_byte", int'(o_data), -1);
        else chk("wire_byte", 32'(o_data), 32'(exp_q.pop_front()));
        run_len++;
      end else begin
        chk("idle_data", 32'(o_data), 32'd0);
        if (fall) begin
          if (frame_q.size() == 0) fail("unexpected_frame", run_len, 0);
          else begin
            fr_m = frame_q.pop_front();
            chk("tx_en_len", 32'(run_len), 32'(fr_m.len));
            chk("error_pulses", 32'(err_seen), 32'(fr_m.err));
          end
          run_len  = 0;
          err_seen = 0;
          gap      = 0;
          have_gap = 1'b1;
        end
        if (have_gap) begin
          gap++;
          if (gap <= 12) chk("busy_in_ifg", 32'(o_busy), 32'd1);
          else if (gap == 13) chk("busy_after_ifg", 32'(o_busy), 32'd0);
        end
      end
      prev_tx = o_tx_en;
    end
  end

  task automatic mid_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_tx_en", 32'(o_tx_en), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd0);
    exp_q.delete();
    frame_q.delete();
    i_valid = 1'b0;
    i_last  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // mode 0: normal, 1: underrun after cut bytes, 2: oversize, 3: reset after cut bytes
  task automatic send(input int mode, input int cut);
    logic [7:0]  body[$];
    logic [31:0] fcs;
    frame_t      fr;
    int          n, limit, idx, waitc;
    bit          rdy;
    n = pay.size();
    body = {};
    case (mode)
      1: for (int k = 0; k < cut; k++) body.push_back(pay[k]);
      2: for (int k = 0; k < MAXF; k++) body.push_back(pay[k]);
      default: begin
        body = pay;
`ifdef ETH_TX_MIN_PAD_EN
        while (body.size() < 60) body.push_back(8'h00);
`endif
      end
    endcase
    fcs = crc_model(body);
    if (mode == 1 || mode == 2) fcs = ~fcs;
    if (use_fcs_ovr) fcs = fcs_ovr;
    for (int k = 0; k < 7; k++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    foreach (body[k]) exp_q.push_back(body[k]);
    for (int k = 0; k < 4; k++) exp_q.push_back(fcs[8*k +: 8]);
    fr.len = 8 + body.size() + 4;
    fr.err = (mode == 1 || mode == 2) ? 1 : 0;
    frame_q.push_back(fr);

    limit = (mode == 1) ? cut : ((mode == 2) ? MAXF : n);
    idx   = 0;
    waitc = 0;
    while (idx < limit) begin
      if (mode == 3 && idx == cut) begin
        mid_reset();
        break;
      end
      i_data  = pay[idx];
      i_last  = (mode == 0 || mode == 3) && (idx == n - 1);
      i_valid = 1'b1;
      rdy     = o_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        idx++;
        waitc = 0;
      end else begin
        waitc++;
        if (waitc > 300) begin
          fail("ready_timeout", idx, limit);
          break;
        end
      end
    end
    if (mode == 2) begin
      i_data  = pay[MAXF];
      i_valid = 1'b1;
      i_last  = 1'b0;
      for (int k = 0; k < 3; k++) begin
        chk("oversize_ready_low", 32'(o_ready), 32'd0);
        @(posedge clk);
        #1;
      end
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic rand_pay(input int n);
    pay = {};
    for (int k = 0; k < n; k++) pay.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || o_busy) && t < 5000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 5000) fail("idle_timeout", exp_q.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int lens[6];
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_data", 32'(o_data), 32'd0);
    chk("reset_tx_en", 32'(o_tx_en), 32'd0);
    chk("reset_ready", 32'(o_ready), 32'd0);
    chk("reset_busy", 32'(o_busy), 32'd0);
    chk("reset_done", 32'(o_frame_done), 32'd0);
    chk("reset_error", 32'(o_error), 32'd0);

    // Known-answer frame "123456789"
    pay = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
`ifndef ETH_TX_MIN_PAD_EN
    use_fcs_ovr = 1'b1;
    fcs_ovr     = 32'hCBF4_3926;
`endif
    send(0, 0);
    use_fcs_ovr = 1'b0;
    wait_idle();

    // 42-byte ARP-sized payload
    rand_pay(42);
    send(0, 0);
    wait_idle();

    // Back-to-back frames with i_valid held high
    rand_pay(30);
    send(0, 0);
    exact_gap = 1'b1;
    rand_pay(25);
    send(0, 0);
    exact_gap = 1'b0;
    wait_idle();

    // Underrun after 20 bytes
    rand_pay(40);
    send(1, 20);
    wait_idle();
    repeat (3) @(posedge clk);
    #1;

    // Oversize: 1515 bytes offered without i_last
    rand_pay(MAXF + 1);
    send(2, 0);
    wait_idle();

    // Reset in the middle of DATA, then a clean 60-byte frame
    rand_pay(60);
    send(3, 20);
    repeat (2) @(posedge clk);
    #1;
    rand_pay(60);
    send(0, 0);
    wait_idle();

    // Boundary and random lengths with random idle spacing
    lens = '{1, 59, 60, 61, 14, 64};
    for (int f = 0; f < 16; f++) begin
      rand_pay((f < 6) ? lens[f] : int'($urandom_range(1, 120)));
      send(0, 0);
      repeat ($urandom_range(0, 4)) @(posedge clk);
      #1;
    end
    wait_idle();
    if (frame_q.size() != 0) fail("frames_outstanding", frame_q.size(), 0);
    repeat (20) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
